// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI slave
package spi_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    localparam logic FBO_MSB = 1'b1;
    localparam logic FBO_LSB = 1'b0;
    localparam logic TX_IDLE_FILL = 1'b1;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer with rise/fall strobes from the last two samples
module spi_sync #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic prev_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= STAGES'({sync_q, d_i});
            prev_q <= sync_q[STAGES-1];
        end
    end
    assign q_o = sync_q[STAGES-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_esclavo.sv
// spi_esclavo: SPI mode-0 slave with TX holding register, RX word register and overrun flag
module spi_esclavo import spi_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  spi_clk_i,
    input  logic                  spi_rst_i,
    input  logic                  SCK_SPI,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic                  spi_enable_i,
    input  logic                  spi_fbo_i,
    input  logic [DATA_WIDTH-1:0] spi_data_i,
    input  logic                  spi_load_i,
    output logic                  spi_txempty_o,
    output logic [DATA_WIDTH-1:0] spi_data_o,
    output logic                  spi_valid_o,
    input  logic                  spi_rd_i,
    output logic                  spi_overrun_o,
    input  logic                  spi_clrflags_i
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] FILL = {DATA_WIDTH{TX_IDLE_FILL}};

    logic sck_s, sck_rise, sck_fall, ss_s, ss_rise, ss_fall, mosi_s, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk_i(spi_clk_i), .rst_i(spi_rst_i), .d_i(SCK_SPI),
        .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk_i(spi_clk_i), .rst_i(spi_rst_i), .d_i(SS),
        .q_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_mosi (
        .clk_i(spi_clk_i), .rst_i(spi_rst_i), .d_i(MOSI),
        .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );
    assign sync_unused = ^{sck_s, mosi_rise, mosi_fall};

    state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, tx_sh_q, tx_sh_d, rx_q, rx_d, data_q, data_d, load_w;
    logic [CW-1:0] cnt_q, cnt_d;
    logic txempty_q, txempty_d, fbo_q, fbo_d, rx_full_q, rx_full_d, overrun_q, overrun_d;
    logic rx_shift, tx_shift;

    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ss_fall ? LOAD : IDLE;
            LOAD:    state_d = SHIFT;
            SHIFT:   state_d = (cnt_d == CW'(DATA_WIDTH)) ? DONE : SHIFT;
            DONE:    state_d = ss_s ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
        if (!spi_enable_i || (state_q != IDLE && ss_rise)) state_d = IDLE;
    end

    always_comb begin
        spi_valid_o = (state_q == DONE);
        MISO = (state_q == IDLE || SS) ? 1'b1
             : (state_q == LOAD) ? (spi_fbo_i ? load_w[DATA_WIDTH-1] : load_w[0])
             : (fbo_q ? tx_sh_q[DATA_WIDTH-1] : tx_sh_q[0]);
    end

    // a fall with cnt_q==0 is the trailing edge of the previous word's last bit
    always_comb begin
        load_w    = txempty_q ? FILL : tx_q;
        rx_shift  = (state_q == SHIFT) && sck_rise;
        tx_shift  = (state_q == SHIFT) && sck_fall && (cnt_q != '0);
        cnt_d     = (state_q == LOAD) ? '0 : rx_shift ? cnt_q + 1'b1 : cnt_q;
        rx_d      = !rx_shift ? rx_q
                  : (fbo_q == FBO_MSB) ? {rx_q[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_q[DATA_WIDTH-1:1]};
        tx_sh_d   = (state_q == LOAD) ? load_w
                  : !tx_shift ? tx_sh_q
                  : (fbo_q == FBO_MSB) ? {tx_sh_q[DATA_WIDTH-2:0], TX_IDLE_FILL} : {TX_IDLE_FILL, tx_sh_q[DATA_WIDTH-1:1]};
        fbo_d     = (state_q == LOAD) ? spi_fbo_i : fbo_q;
        tx_d      = spi_load_i ? spi_data_i : tx_q;
        txempty_d = spi_load_i ? 1'b0 : (txempty_q | (state_q == LOAD));
        data_d    = (state_q == SHIFT && state_d == DONE) ? rx_d : data_q;
        rx_full_d = (state_q == DONE) | (rx_full_q & ~spi_rd_i);
        overrun_d = (state_q == DONE && rx_full_q && !spi_rd_i) | (overrun_q & ~spi_clrflags_i);
    end

    always_ff @(posedge spi_clk_i or posedge spi_rst_i) begin
        if (spi_rst_i) begin
            tx_q      <= FILL;
            tx_sh_q   <= FILL;
            rx_q      <= FILL;
            data_q    <= '0;
            cnt_q     <= '0;
            txempty_q <= 1'b1;
            fbo_q     <= FBO_MSB;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tx_q      <= tx_d;
            tx_sh_q   <= tx_sh_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            txempty_q <= txempty_d;
            fbo_q     <= fbo_d;
            rx_full_q <= rx_full_d;
            overrun_q <= overrun_d;
        end
    end

    assign spi_txempty_o = txempty_q;
    assign spi_data_o    = data_q;
    assign spi_overrun_o = overrun_q;
endmodule

// File: tb/tb_spi_esclavo.sv
// tb_spi_esclavo: directed mode-0 master driving spi_esclavo with hand-computed expectations
module tb_spi_esclavo;
    import spi_pkg::*;

    logic clk = 0, rst = 1, sck = 0, ss = 1, mosi = 1, en = 0, fbo = 1;
    logic load = 0, rd = 0, clr = 0;
    logic [7:0] din = 8'h00;
    logic miso, txempty, valid, overrun;
    logic [7:0] dout, mw;
    int total = 0, bad = 0, vcnt = 0, v0;
    time vtime = 0, rtime = 0;

    spi_esclavo #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .spi_clk_i(clk), .spi_rst_i(rst), .SCK_SPI(sck), .SS(ss), .MOSI(mosi), .MISO(miso),
        .spi_enable_i(en), .spi_fbo_i(fbo), .spi_data_i(din), .spi_load_i(load),
        .spi_txempty_o(txempty), .spi_data_o(dout), .spi_valid_o(valid), .spi_rd_i(rd),
        .spi_overrun_o(overrun), .spi_clrflags_i(clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (valid) begin
        vcnt++;
        vtime = $time;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_load(input logic [7:0] d);
        din = d;
        load = 1;
        @(negedge clk);
        load = 0;
    endtask

    task automatic pulse_rd();
        rd = 1;
        @(negedge clk);
        rd = 0;
    endtask

    task automatic xfer(input logic [7:0] w, input int n, output logic [7:0] m);
        int k;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            k = fbo ? 7 - i : i;
            mosi = w[k];
            repeat (8) @(negedge clk);
            sck = 1;
            rtime = $time;
            m[k] = miso;
            repeat (8) @(negedge clk);
            sck = 0;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 1);
        chk("rst_data", 32'(dout), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_txempty", 32'(txempty), 1);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 0;
        en = 1;
        repeat (4) @(negedge clk);

        pulse_load(8'hA5);
        chk("load_txempty", 32'(txempty), 0);
        fbo = 1;
        v0 = vcnt;
        ss = 0;
        repeat (8) @(negedge clk);
        xfer(8'h3C, 8, mw);
        repeat (4) @(negedge clk);
        chk("msb_miso", 32'(mw), 32'hA5);
        chk("msb_data", 32'(dout), 32'h3C);
        chk("msb_valid_cnt", 32'(vcnt - v0), 1);
        chk("msb_latency", 32'(vtime - rtime), 30);
        chk("msb_txempty", 32'(txempty), 1);
        ss = 1;
        repeat (8) @(negedge clk);
        chk("idle_miso", 32'(miso), 1);
        pulse_rd();

        pulse_load(8'h80);
        fbo = 0;
        v0 = vcnt;
        ss = 0;
        repeat (8) @(negedge clk);
        chk("lsb_first_bit", 32'(miso), 0);
        xfer(8'h01, 8, mw);
        repeat (4) @(negedge clk);
        chk("lsb_miso", 32'(mw), 32'h80);
        chk("lsb_data", 32'(dout), 32'h01);
        chk("lsb_valid_cnt", 32'(vcnt - v0), 1);
        ss = 1;
        repeat (8) @(negedge clk);
        pulse_rd();

        pulse_load(8'h5A);
        fbo = 1;
        v0 = vcnt;
        ss = 0;
        repeat (8) @(negedge clk);
        xfer(8'h11, 8, mw);
        chk("burst1_miso", 32'(mw), 32'h5A);
        chk("burst1_data", 32'(dout), 32'h11);
        chk("burst1_overrun", 32'(overrun), 0);
        xfer(8'h22, 8, mw);
        repeat (4) @(negedge clk);
        chk("burst2_miso", 32'(mw), 32'hFF);
        chk("burst2_txempty", 32'(txempty), 1);
        chk("burst2_data", 32'(dout), 32'h22);
        chk("burst_valid_cnt", 32'(vcnt - v0), 2);
        chk("overrun_set", 32'(overrun), 1);
        ss = 1;
        repeat (8) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        chk("overrun_clr", 32'(overrun), 0);
        chk("overrun_keep_data", 32'(dout), 32'h22);
        pulse_rd();

        v0 = vcnt;
        ss = 0;
        repeat (8) @(negedge clk);
        xfer(8'hE7, 5, mw);
        ss = 1;
        repeat (10) @(negedge clk);
        chk("abort_valid_cnt", 32'(vcnt - v0), 0);
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        chk("abort_miso", 32'(miso), 1);
        chk("abort_data", 32'(dout), 32'h22);
        pulse_load(8'h96);
        v0 = vcnt;
        ss = 0;
        repeat (8) @(negedge clk);
        xfer(8'hC3, 8, mw);
        repeat (4) @(negedge clk);
        chk("after_abort_miso", 32'(mw), 32'h96);
        chk("after_abort_data", 32'(dout), 32'hC3);
        chk("after_abort_valid", 32'(vcnt - v0), 1);
        chk("after_abort_overrun", 32'(overrun), 0);
        ss = 1;
        repeat (8) @(negedge clk);
        pulse_rd();

        en = 0;
        ss = 0;
        repeat (10) @(negedge clk);
        chk("dis_state", 32'(dut.state_q), 32'(IDLE));
        chk("dis_data", 32'(dout), 32'hC3);
        ss = 1;
        repeat (8) @(negedge clk);
        en = 1;
        repeat (2) @(negedge clk);

        pulse_load(8'h33);
        v0 = vcnt;
        ss = 0;
        repeat (8) @(negedge clk);
        xfer(8'hF0, 4, mw);
        chk("mid_state", 32'(dut.state_q), 32'(SHIFT));
        rst = 1;
        #1;
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("mid_rst_miso", 32'(miso), 1);
        chk("mid_rst_data", 32'(dout), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        chk("mid_rst_txempty", 32'(txempty), 1);
        ss = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_valid", 32'(vcnt - v0), 0);
        chk("mid_rst_idle", 32'(dut.state_q), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
